// File: rtl/mha_pkg.sv
// Shared definitions for the MHA systolic operand path: default element
// width and array edge, feeder state encoding, and the beat-counter sizing
// helper.
package mha_pkg;

    localparam int unsigned MHA_DATA_W = 8;
    localparam int unsigned MHA_LANES  = 4;

    typedef enum logic [1:0] {
        FEED_IDLE   = 2'd0,
        FEED_STREAM = 2'd1,
        FEED_DRAIN  = 2'd2
    } feed_state_e;

    // Bits needed to count beats 0 .. k_max+lanes-1 inclusive.
    function automatic int unsigned beat_cnt_w(input int unsigned k_max,
                                               input int unsigned lanes);
        return (k_max + lanes <= 2) ? 1 : $clog2(k_max + lanes);
    endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Per-lane skew delay: DEPTH-stage shift register that advances only when
// en is high. The output is the element shifted in DEPTH enables ago, read
// before the current shift. DEPTH=0 is a combinational pass-through.
module skew_delay_line #(
    parameter int unsigned DEPTH  = 1,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_pass;
            assign unused_pass = ^{clk, reset, en};
            assign dout        = din;
        end else begin : g_shift
            logic [DATA_W-1:0] sr_q [DEPTH];
            logic [DATA_W-1:0] sr_d [DEPTH];

            // Shift the new element in at stage 0 when enabled.
            always_comb begin
                sr_d = sr_q;
                if (en) begin
                    sr_d[0] = din;
                    for (int unsigned j = 1; j < DEPTH; j++) begin
                        sr_d[j] = sr_q[j-1];
                    end
                end
            end

            // Stage registers with synchronous active-low clear.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    for (int unsigned j = 0; j < DEPTH; j++) begin
                        sr_q[j] <= '0;
                    end
                end else begin
                    sr_q <= sr_d;
                end
            end

            assign dout = sr_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/systolic_skew_feeder.sv
// Transmit side of the systolic array operand interface. Accepts one row of
// a K-deep tile per handshake and emits diagonally skewed beats (lane i
// delayed i beats), followed by LANES-1 drain beats.
// Optional: define FEEDER_STALL_CNT_EN to add the 16-bit stall_cycles
// counter output (saturating count of out_valid && !out_ready cycles).
module systolic_skew_feeder
    import mha_pkg::*;
#(
    parameter int unsigned DATA_W = MHA_DATA_W,
    parameter int unsigned LANES  = MHA_LANES,
    parameter int unsigned K_MAX  = 16,
    parameter int unsigned KW     = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [KW-1:0]           cfg_k,
    output logic                    busy,
    input  logic [LANES*DATA_W-1:0] in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [LANES*DATA_W-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_first,
    output logic                    out_last,
`ifdef FEEDER_STALL_CNT_EN
    output logic [15:0]             stall_cycles,
`endif
    output logic                    tile_done
);

    localparam int unsigned BW = beat_cnt_w(K_MAX, LANES);
    typedef logic [BW-1:0] beat_t;

    feed_state_e             state_q, state_d;
    logic [KW-1:0]           k_q, k_d;
    beat_t                   beat_q, beat_d;
    logic [LANES*DATA_W-1:0] out_data_q, out_data_d;
    logic                    out_valid_q, out_valid_d;
    logic                    out_first_q, out_first_d;
    logic                    out_last_q, out_last_d;
    logic                    tile_done_q, tile_done_d;

    logic                    adv;
    logic                    row_acc;
    logic                    drain_step;
    logic                    shift_en;
    logic [KW-1:0]           k_clamp;
    beat_t                   stream_last_idx;
    beat_t                   tile_last_idx;
    logic [LANES*DATA_W-1:0] skew_beat;
    logic [DATA_W-1:0]       lane_din  [LANES];
    logic [DATA_W-1:0]       lane_dout [LANES];

    assign adv        = !out_valid_q || out_ready;
    assign row_acc    = (state_q == FEED_STREAM) && in_valid && adv;
    assign drain_step = (state_q == FEED_DRAIN) && adv;
    assign shift_en   = row_acc || drain_step;
    assign k_clamp    = (cfg_k > KW'(K_MAX)) ? KW'(K_MAX) : cfg_k;

    assign stream_last_idx = beat_t'(k_q) - beat_t'(1);
    assign tile_last_idx   = beat_t'(k_q) + beat_t'(LANES) - beat_t'(2);

    // Lane i taps the row from i shifts ago; drain feeds zeros behind the
    // last row so the tail of every lane empties out and the lines end the
    // tile cleared for the next one.
    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            assign lane_din[i] = (state_q == FEED_STREAM)
                               ? in_data[i*DATA_W +: DATA_W] : '0;

            skew_delay_line #(
                .DEPTH  (i),
                .DATA_W (DATA_W)
            ) u_delay (
                .clk   (clk),
                .reset (reset),
                .en    (shift_en),
                .din   (lane_din[i]),
                .dout  (lane_dout[i])
            );

            assign skew_beat[i*DATA_W +: DATA_W] = lane_dout[i];
        end
    endgenerate

    // Next-state: FSM transitions, beat counter and output register loading.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        beat_d      = beat_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_first_d = out_first_q;
        out_last_d  = out_last_q;
        tile_done_d = out_valid_q && out_ready && out_last_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            out_first_d = 1'b0;
            out_last_d  = 1'b0;
            out_data_d  = '0;
        end

        if (shift_en) begin
            out_data_d  = skew_beat;
            out_valid_d = 1'b1;
            out_first_d = (beat_q == '0);
            out_last_d  = (beat_q == tile_last_idx);
            beat_d      = beat_q + beat_t'(1);
        end

        case (state_q)
            FEED_IDLE: begin
                if (start && (cfg_k != '0)) begin
                    state_d = FEED_STREAM;
                    k_d     = k_clamp;
                    beat_d  = '0;
                end
            end
            FEED_STREAM: begin
                if (row_acc && (beat_q == stream_last_idx)) begin
                    state_d = (LANES > 1) ? FEED_DRAIN : FEED_IDLE;
                end
            end
            FEED_DRAIN: begin
                if (drain_step && (beat_q == tile_last_idx)) begin
                    state_d = FEED_IDLE;
                end
            end
            default: state_d = FEED_IDLE;
        endcase
    end

    // State and registered outputs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= FEED_IDLE;
            k_q         <= '0;
            beat_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
            tile_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            beat_q      <= beat_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_first_q <= out_first_d;
            out_last_q  <= out_last_d;
            tile_done_q <= tile_done_d;
        end
    end

    assign busy      = (state_q != FEED_IDLE);
    assign in_ready  = (state_q == FEED_STREAM) && adv;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_first = out_first_q;
    assign out_last  = out_last_q;
    assign tile_done = tile_done_q;

`ifdef FEEDER_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Saturating stall counter, cleared when a tile start is accepted.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == FEED_IDLE) && start && (cfg_k != '0)) begin
            stall_cnt_d = '0;
        end else if (out_valid_q && !out_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: doc/systolic_skew_feeder.md
Name: systolic_skew_feeder

Overview:
- Transmit side of the 4x4 systolic array's operand interface inside MHA.
- Accepts one row of a K-deep operand tile per handshake (one element per lane).
- Emits diagonally skewed beats: lane i is delayed i beats, so each PE column receives aligned operands.
- After the last row, appends LANES-1 drain beats so the array's column accumulators complete.

Parameters:
- DATA_W, 8, operand element width in bits.
- LANES, 4, array edge length (lanes per beat).
- K_MAX, 16, maximum tile depth (rows per tile).
- KW, 5, width of cfg_k; must satisfy 2^KW > K_MAX.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset; all state clears on a clk edge while reset==0.
- start  in  1  one-cycle tile start; sampled only in IDLE.
- cfg_k  in  KW  tile depth; latched on accepted start.
- busy  out  1  high in any state other than IDLE.
- in_data  in  LANES*DATA_W  row vector; lane i occupies bits [i*DATA_W +: DATA_W].
- in_valid  in  1  row valid.
- in_ready  out  1  row accepted when in_valid&&in_ready.
- out_data  out  LANES*DATA_W  skewed beat to the array.
- out_valid  out  1  beat valid.
- out_ready  in  1  array accepts the beat.
- out_first  out  1  qualifies beat 0 of the tile.
- out_last  out  1  qualifies the final beat (K+LANES-2).
- tile_done  out  1  one-cycle pulse after the last beat handshake.

Behaviour:
- Reset values: all outputs 0, state=IDLE, skew registers 0, beat counter 0.
- FSM states are IDLE, STREAM, DRAIN.
- IDLE -> STREAM on start with cfg_k!=0. K = min(cfg_k, K_MAX). If cfg_k==0, start is ignored.
- Output stage is a single register. The skew chain advances when adv = !out_valid || out_ready.
- STREAM:
  - in_ready = adv.
  - On an accepted row, beat t is loaded: lane0 = incoming row lane0; lane i = lane-i element of row t-i from the delay line, or 0 if t-i<0.
  - The delay lines shift in the current row.
  - After row K-1 is accepted: go to DRAIN if LANES>1, otherwise go to IDLE.
- DRAIN:
  - in_ready = 0.
  - On each adv, beat t loads with lane i = row t-i if t-i<K, else 0; the delay lines shift in zeros.
  - After loading beat K+LANES-2, go to IDLE.
- Total beats per tile is K+LANES-1.
- Latency: a row accepted at edge n puts its lane0 element on out_data after edge n.
- Bubbles: when in_valid is low in STREAM, no beat is generated. The skew alignment is preserved because the chain never advances without a row.
- Stall: when out_valid&&!out_ready, out_data, out_first and out_last hold stable and no row is accepted.
- tile_done asserts for one cycle after the edge on which the out_last beat handshakes.
- start while busy is ignored. A new start is legal in the cycle tile_done is high.
- Reset mid-tile: the next cycle is IDLE with outputs 0. The partial tile is discarded and nothing is emitted afterwards.

Optional Feature:
- Macro: FEEDER_STALL_CNT_EN.
- When defined:
  - Adds output port stall_cycles (16 bits).
  - Counts cycles with out_valid&&!out_ready, saturating at 0xFFFF.
  - Clears on accepted start and on reset.
- When undefined: the port and the counter are absent; behaviour is otherwise identical.

Decomposition:
- Package mha_pkg holds:
  - the DATA_W and LANES defaults;
  - the feeder state encoding (IDLE=2'd0, STREAM=2'd1, DRAIN=2'd2);
  - the beat-count width function.
- Sub-module skew_delay_line (parameters DEPTH, DATA_W), with enable-gated shift, is instantiated once per lane i with DEPTH=i. Lane 0 is a pass-through.

Test Plan:
- K=4, rows 0x04030201, 0x08070605, 0x0C0B0A09, 0x100F0E0D, out_ready=1 -> seven beats 0x00000001, 0x00000205, 0x00030609, 0x04070A0D, 0x080B0E00, 0x0C0F0000, 0x10000000; out_first on beat 0, out_last on beat 6, tile_done one cycle later.
- Same tile with out_ready low for 3 cycles at beat 2 -> beat 2 holds 0x00030609 throughout the stall, in_ready=0, and the sequence resumes unchanged; with FEEDER_STALL_CNT_EN, stall_cycles=3.
- Same tile with in_valid low for 2 cycles between rows 1 and 2 -> the identical seven-beat sequence with no zero beats inserted.
- cfg_k=0 start -> busy stays 0 and no beats are emitted. cfg_k=20 -> K clamps to 16 and 19 beats are emitted.
- reset=0 asserted during beat 3 -> the next cycle has out_valid=0 and busy=0; a fresh K=1 tile with row 0xAABBCCDD yields beats 0x000000DD, 0x0000CC00, 0x00BB0000, 0xAA000000.
- start in the same cycle as tile_done -> the second tile's beat 0 follows without an idle gap beyond one cycle.
